// File: rtl/wb_lcd_sequencer_pkg.sv
// Shared types and constants for the HD44780 Wishbone sequencer.
// Holds the FSM state encodings, counter widths and the LCD command bytes.
package lcd_seq_pkg;

    localparam int STEP_W        = 6;
    localparam int GAP_CNT_W     = 20;
    localparam int TO_CNT_W      = 8;
    localparam int BUF_DEPTH     = 32;
    localparam int INIT_STEPS    = 4;
    localparam int REFRESH_STEPS = 34;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_REFRESH} seq_state_t;
    typedef enum logic       {PH_BUS, PH_GAP} seq_phase_t;
    typedef enum logic [1:0] {WB_IDLE, WB_ISSUE, WB_WAIT_ACK} wb_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/wb_lcd_sequencer_wbm.sv
// Single-transfer pipelined Wishbone write master with an ack timeout.
// One request at a time: start -> strobe until accepted -> wait for ack or give up.
module lcd_wb_single_master
    import lcd_seq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_rs,
    input  logic [7:0]  i_byte,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic        o_done,
    output logic        o_timeout
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TIMEOUT - 1);

    wb_state_t           r_state;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic                r_rs;
    logic [7:0]          r_byte;
    logic [TO_CNT_W-1:0] r_tcnt;
    logic                r_done;
    logic                r_timeout;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= WB_IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_rs      <= 1'b0;
            r_byte    <= 8'h00;
            r_tcnt    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    // Acks arriving here belong to nobody and are dropped.
                    if (i_start) begin
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_rs    <= i_rs;
                        r_byte  <= i_byte;
                        r_state <= WB_ISSUE;
                    end
                end
                WB_ISSUE: begin
                    if (!i_wb_stall) begin
                        r_stb   <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= WB_WAIT_ACK;
                    end
                end
                WB_WAIT_ACK: begin
                    if (i_wb_ack) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= WB_IDLE;
                    end else if (r_tcnt == TO_LAST) begin
                        r_cyc     <= 1'b0;
                        r_we      <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= WB_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_CNT_W'(1);
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    assign o_wb_cyc  = r_cyc;
    assign o_wb_stb  = r_stb;
    assign o_wb_we   = r_we;
    assign o_wb_addr = {29'd0, r_rs};
    assign o_wb_data = {24'd0, r_byte};
    assign o_wb_sel  = 4'b0001;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;

endmodule

// File: rtl/wb_lcd_sequencer.sv
// HD44780 sequencer: power-on delay, init commands, then mirrors a 2x16 buffer
// to the panel over Wishbone whenever the buffer changes or a refresh is requested.
module wb_lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned CMD_GAP_CYCLES = 2500,
    parameter int unsigned CLEAR_CYCLES   = 100000,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_buf_we,
    input  logic [4:0]  i_buf_addr,
    input  logic [7:0]  i_buf_data,
    input  logic        i_refresh_req,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_error,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    localparam logic [GAP_CNT_W-1:0] PWR_LAST = GAP_CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(CMD_GAP_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] CLR_LAST = GAP_CNT_W'(CLEAR_CYCLES - 1);

    logic [7:0]           r_buf [BUF_DEPTH];
    logic                 r_dirty;
    logic                 r_req_pend;
    seq_state_t           r_state;
    seq_phase_t           r_phase;
    logic [STEP_W-1:0]    r_step;
    logic [GAP_CNT_W-1:0] r_cnt;
    logic                 r_start;
    logic                 r_init_done;
    logic                 r_busy;
    logic                 r_error;

    logic                 w_go;
    logic                 w_rs;
    logic [7:0]           w_byte;
    logic                 w_last_step;
    logic [GAP_CNT_W-1:0] w_gap_last;
    logic                 w_done;
    logic                 w_timeout;

    assign w_go = (r_state == ST_IDLE) && (r_dirty || r_req_pend || i_refresh_req);

    // A write landing on the same cycle a refresh starts keeps the buffer dirty.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= 8'h20;
            r_dirty    <= 1'b1;
            r_req_pend <= 1'b0;
        end else begin
            if (i_buf_we) r_buf[i_buf_addr] <= i_buf_data;
            if (i_buf_we)  r_dirty <= 1'b1;
            else if (w_go) r_dirty <= 1'b0;
            if (w_go)               r_req_pend <= 1'b0;
            else if (i_refresh_req) r_req_pend <= 1'b1;
        end
    end

    always_comb begin
        w_rs   = 1'b0;
        w_byte = LCD_FUNC_SET;
        if (r_state == ST_INIT) begin
            w_byte = init_cmd(r_step[1:0]);
        end else if (r_state == ST_REFRESH) begin
            if (r_step == STEP_W'(0)) begin
                w_byte = LCD_LINE1;
            end else if (r_step <= STEP_W'(16)) begin
                w_rs   = 1'b1;
                w_byte = r_buf[5'(r_step - STEP_W'(1))];
            end else if (r_step == STEP_W'(17)) begin
                w_byte = LCD_LINE2;
            end else begin
                w_rs   = 1'b1;
                w_byte = r_buf[5'(r_step - STEP_W'(2))];
            end
        end
    end

    assign w_last_step = (r_state == ST_INIT) ? (r_step == STEP_W'(INIT_STEPS - 1))
                                              : (r_step == STEP_W'(REFRESH_STEPS - 1));
    // Only a clear command (RS=0) earns the long gap; data byte 0x01 does not.
    assign w_gap_last  = (!w_rs && w_byte == LCD_CLEAR) ? CLR_LAST : GAP_LAST;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_POWERUP;
            r_phase     <= PH_BUS;
            r_step      <= '0;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_timeout) r_error <= 1'b1;
            case (r_state)
                ST_POWERUP: begin
                    r_busy <= 1'b1;
                    if (r_cnt == PWR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_INIT;
                        r_phase <= PH_BUS;
                        r_step  <= '0;
                        r_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + GAP_CNT_W'(1);
                    end
                end
                ST_INIT, ST_REFRESH: begin
                    if (r_phase == PH_BUS) begin
                        if (w_done) begin
                            r_phase <= PH_GAP;
                            r_cnt   <= '0;
                        end
                    end else if (r_cnt == w_gap_last) begin
                        r_cnt   <= '0;
                        r_phase <= PH_BUS;
                        if (w_last_step) begin
                            if (r_state == ST_INIT) r_init_done <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_step  <= '0;
                        end else begin
                            r_step  <= r_step + STEP_W'(1);
                            r_start <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + GAP_CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_REFRESH;
                        r_phase <= PH_BUS;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lcd_wb_single_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wbm (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (r_start),
        .i_rs       (w_rs),
        .i_byte     (w_byte),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .o_done     (w_done),
        .o_timeout  (w_timeout)
    );

    assign o_init_done = r_init_done;
    assign o_busy      = r_busy;
    assign o_error     = r_error;

endmodule

// File: tb/tb_wb_lcd_sequencer.sv
// Randomized bench for wb_lcd_sequencer: random-latency slave plus a queue of
// expected LCD writes derived from the init list and a model of the text buffer.
module tb_wb_lcd_sequencer;

    localparam int PWR = 20;
    localparam int GAP = 4;
    localparam int CLR = 10;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        buf_we;
    logic [4:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        refresh_req;
    logic        init_done, busy, error;
    logic        cyc, stb, we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        ack, stall;

    always #5 clk = ~clk;

    wb_lcd_sequencer #(
        .POWERUP_CYCLES (PWR),
        .CMD_GAP_CYCLES (GAP),
        .CLEAR_CYCLES   (CLR),
        .ACK_TIMEOUT    (TO)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_buf_we      (buf_we),
        .i_buf_addr    (buf_addr),
        .i_buf_data    (buf_data),
        .i_refresh_req (refresh_req),
        .o_init_done   (init_done),
        .o_busy        (busy),
        .o_error       (error),
        .o_wb_cyc      (cyc),
        .o_wb_stb      (stb),
        .o_wb_we       (we),
        .o_wb_addr     (addr),
        .o_wb_data     (data),
        .o_wb_sel      (sel),
        .i_wb_ack      (ack),
        .i_wb_stall    (stall)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected writes: value < 256 is a command byte, 256+i is data from buffer slot i.
    logic [7:0] mbuf [32];
    int         expq [$];
    int         xfer_cnt   = 0;
    int         cyc_cnt    = 0;
    int         noack_at   = -1;
    int         stall_left = -1;
    int         ack_wait   = 0;
    bit         drop       = 0;
    bit         last_clear = 0;
    bit         clr_meas   = 0;
    int         clr_ack_t  = 0;
    int         to_acc_t   = -1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_init();
        expq.push_back('h38);
        expq.push_back('h0C);
        expq.push_back('h01);
        expq.push_back('h06);
    endtask

    task automatic push_refresh();
        expq.push_back('h80);
        for (int i = 0; i < 16; i++) expq.push_back(256 + i);
        expq.push_back('hC0);
        for (int i = 16; i < 32; i++) expq.push_back(256 + i);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    endtask

    task automatic buf_write(input int a, input int d);
        @(negedge clk);
        buf_we   = 1'b1;
        buf_addr = 5'(a);
        buf_data = 8'(d);
        mbuf[a]  = 8'(d);
        @(negedge clk);
        buf_we   = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((expq.size() != 0 || busy || cyc) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_budget", k < budget, 1);
        repeat (30) @(negedge clk);
        chk("idle_not_busy", busy, 0);
        chk("idle_queue_empty", expq.size(), 0);
    endtask

    task automatic wait_xfer(input int n);
        int k = 0;
        while (xfer_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_xfer", xfer_cnt >= n, 1);
    endtask

    task automatic wait_init_done();
        int k = 0;
        while (!init_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("init_done_set", init_done, 1);
    endtask

    // Slave model and transfer monitor, evaluated on the falling edge.
    initial begin
        int         e;
        logic       ers;
        logic [7:0] eb;
        ack   = 1'b0;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (!rst_n) begin
                ack        = 1'b0;
                stall      = 1'b0;
                stall_left = -1;
                ack_wait   = 0;
                clr_meas   = 0;
                last_clear = 0;
                to_acc_t   = -1;
                continue;
            end
            ack = 1'b0;
            if (ack_wait > 0) begin
                ack_wait--;
                if (ack_wait == 0 && !drop) begin
                    ack = 1'b1;
                    if (last_clear) begin
                        clr_meas  = 1;
                        clr_ack_t = cyc_cnt;
                    end
                end
            end else if (!cyc && $urandom_range(0, 3) == 0) begin
                ack = 1'b1;
            end
            if (to_acc_t >= 0 && !cyc) begin
                chk("ack_timeout_cycles", cyc_cnt - to_acc_t - 1, TO);
                to_acc_t = -1;
            end
            if (cyc && stb) begin
                if (stall_left < 0) begin
                    stall_left = $urandom_range(0, 3);
                    if (clr_meas) begin
                        chk("clear_gap_min", (cyc_cnt - clr_ack_t - 1) >= CLR, 1);
                        clr_meas = 0;
                    end
                end
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else begin
                    stall      = 1'b0;
                    stall_left = -1;
                    drop       = (xfer_cnt == noack_at);
                    last_clear = (addr[0] == 1'b0 && data[7:0] == 8'h01);
                    if (drop) to_acc_t = cyc_cnt;
                    ack_wait = $urandom_range(1, 5);
                    if (expq.size() == 0) begin
                        chk("xfer_expected", expq.size(), 1);
                    end else begin
                        e   = expq.pop_front();
                        ers = (e >= 256);
                        eb  = ers ? mbuf[e - 256] : 8'(e);
                        chk("xfer", {we, sel, addr, data},
                            {1'b1, 4'b0001, 29'd0, ers, 24'd0, eb});
                    end
                    xfer_cnt++;
                end
            end else begin
                stall = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin
        bit saw;
        int base;
        int k;
        rst_n       = 1'b0;
        buf_we      = 1'b0;
        buf_addr    = '0;
        buf_data    = '0;
        refresh_req = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_we", {cyc, stb, we}, 0);
        chk("rst_addr_data", {addr, data}, 0);
        chk("rst_status", {init_done, busy, error}, 0);

        push_init();
        push_refresh();
        rst_n = 1'b1;
        saw = 0;
        repeat (PWR) begin
            @(negedge clk);
            if (cyc) saw = 1;
        end
        chk("powerup_quiet", saw, 0);
        chk("init_done_early", init_done, 0);
        wait_init_done();
        chk("init_four_cmds", expq.size(), 34);
        drain(3000);

        push_refresh();
        buf_write(5, 'h41);
        drain(3000);

        repeat (6) begin
            int a, d;
            a = $urandom_range(0, 31);
            d = $urandom_range(0, 255);
            push_refresh();
            buf_write(a, d);
            drain(3000);
        end

        // Clean buffer, explicit refresh; buffer write lands mid-refresh.
        base = xfer_cnt;
        push_refresh();
        pulse_req();
        wait_xfer(base + 10);
        push_refresh();
        buf_write(20, 'h42);
        drain(4000);

        // Refresh request during a refresh is held and served afterwards.
        base = xfer_cnt;
        push_refresh();
        pulse_req();
        wait_xfer(base + 3);
        push_refresh();
        pulse_req();
        drain(4000);

        // Reset while a request is on the bus.
        push_refresh();
        pulse_req();
        k = 0;
        while (!stb && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("stb_seen", stb, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_drop", {cyc, stb}, 0);
        chk("rst_clears_init", init_done, 0);
        expq.delete();
        model_clear();
        repeat (2) @(negedge clk);
        push_init();
        push_refresh();
        noack_at = xfer_cnt + 3;
        chk("error_clear", error, 0);
        rst_n = 1'b1;
        wait_init_done();
        drain(4000);
        chk("error_sticky", error, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
